// File: rtl/mult_share_arbiter.sv
// Two-requester round-robin front end that time-shares one 4x4 array multiplier.
// Each transaction runs accept -> multiply -> hold response until the owner consumes it.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_add4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] sum,
  output logic       cout
);
  logic c1, c2, c3;

  full_adder fa0 (.a(x[0]), .b(y[0]), .cin(1'b0), .sum(sum[0]), .cout(c1));
  full_adder fa1 (.a(x[1]), .b(y[1]), .cin(c1),   .sum(sum[1]), .cout(c2));
  full_adder fa2 (.a(x[2]), .b(y[2]), .cin(c2),   .sum(sum[2]), .cout(c3));
  full_adder fa3 (.a(x[3]), .b(y[3]), .cin(c3),   .sum(sum[3]), .cout(cout));
endmodule

module mult4x4_array (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] pp0, pp1, pp2, pp3;
  logic [3:0] s1, s2, s3;
  logic       c1, c2, c3;

  assign pp0 = a & {4{b[0]}};
  assign pp1 = a & {4{b[1]}};
  assign pp2 = a & {4{b[2]}};
  assign pp3 = a & {4{b[3]}};

  // Each row adds the next partial product to the running sum shifted down one column.
  ripple_add4 row1 (.x({1'b0, pp0[3:1]}), .y(pp1), .sum(s1), .cout(c1));
  ripple_add4 row2 (.x({c1, s1[3:1]}),    .y(pp2), .sum(s2), .cout(c2));
  ripple_add4 row3 (.x({c2, s2[3:1]}),    .y(pp3), .sum(s3), .cout(c3));

  assign p = {c3, s3, s2[0], s1[0], pp0[0]};
endmodule

module mult_share_arbiter #(
  parameter int RR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_p,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_p,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, MUL, RSP} state_t;

  state_t     state, state_next;
  logic       rr_ptr;
  logic       owner;
  logic [3:0] op_a, op_b;
  logic [7:0] result;
  logic [7:0] mult_p;
  logic       grant_valid, grant_id;
  logic       handshake;
  logic       owner_rsp_ready;

  mult4x4_array u_mult (.a(op_a), .b(op_b), .p(mult_p));

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = rr_ptr;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = rr_ptr;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  // Ready is masked by rst_n so it drops the instant reset asserts.
  assign req0_ready = rst_n & grant_valid & ~grant_id;
  assign req1_ready = rst_n & grant_valid & grant_id;
  assign handshake  = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = MUL;
      MUL:     state_next = RSP;
      RSP:     if (owner_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'(RR_INIT);
      owner  <= 1'b0;
      op_a   <= 4'd0;
      op_b   <= 4'd0;
      result <= 8'd0;
    end else begin
      if (handshake) begin
        owner  <= grant_id;
        rr_ptr <= ~grant_id;
        op_a   <= grant_id ? req1_a : req0_a;
        op_b   <= grant_id ? req1_b : req0_b;
      end
      if (state == MUL) result <= mult_p;
    end
  end

  assign rsp0_valid = (state == RSP) & ~owner;
  assign rsp1_valid = (state == RSP) & owner;
  assign rsp0_p     = rsp0_valid ? result : 8'd0;
  assign rsp1_p     = rsp1_valid ? result : 8'd0;
  assign busy       = (state != IDLE);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed scenarios with literal expectations, then
// an exhaustive operand sweep and random traffic checked every cycle by a transaction model.

module tb_mult_share_arbiter;
  localparam int RR_INIT = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [3:0] req0_a, req0_b;
  logic [7:0] rsp0_p;
  logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [3:0] req1_a, req1_b;
  logic [7:0] rsp1_p;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.RR_INIT(RR_INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_p(rsp0_p),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_p(rsp1_p),
    .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                               input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                               input logic r0, input logic r1);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp0_ready = r0; rsp1_ready = r1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic doReset();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
  endtask

  task automatic drain();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    repeat (4) tick();
  endtask

  // Transaction-level model: one job at a time; response visible from two cycles after acceptance.
  logic       m_busy = 1'b0;
  logic       m_owner = 1'b0;
  logic       m_ptr = 1'(RR_INIT);
  int         m_age = 0;
  logic [7:0] m_prod = 8'd0;
  logic       e_r0, e_r1, e_v0, e_v1, e_busy;
  logic [7:0] e_p0, e_p1;

  always begin : compare_proc
    @(negedge clk);
    #3;
    e_r0 = 0; e_r1 = 0; e_v0 = 0; e_v1 = 0; e_busy = 0; e_p0 = 0; e_p1 = 0;
    if (!rst_n) begin
      m_busy = 0;
      m_ptr  = 1'(RR_INIT);
      m_age  = 0;
    end else if (!m_busy) begin
      e_r0 = req0_valid && (!req1_valid || m_ptr == 1'b0);
      e_r1 = req1_valid && (!req0_valid || m_ptr == 1'b1);
    end else begin
      e_busy = 1;
      if (m_age >= 2) begin
        e_v0 = (m_owner == 1'b0);
        e_v1 = (m_owner == 1'b1);
        e_p0 = e_v0 ? m_prod : 8'd0;
        e_p1 = e_v1 ? m_prod : 8'd0;
      end
    end
    checkOutput("req0_ready", 9'(req0_ready), 9'(e_r0));
    checkOutput("req1_ready", 9'(req1_ready), 9'(e_r1));
    checkOutput("rsp0_valid", 9'(rsp0_valid), 9'(e_v0));
    checkOutput("rsp1_valid", 9'(rsp1_valid), 9'(e_v1));
    checkOutput("rsp0_p", 9'(rsp0_p), 9'(e_p0));
    checkOutput("rsp1_p", 9'(rsp1_p), 9'(e_p1));
    checkOutput("busy", 9'(busy), 9'(e_busy));
    checkOutput("two_req_ready", 9'(req0_ready & req1_ready), 9'd0);
    checkOutput("two_rsp_valid", 9'(rsp0_valid & rsp1_valid), 9'd0);
    if (rst_n) begin
      if (!m_busy) begin
        if (e_r0) begin
          m_busy = 1; m_owner = 0; m_ptr = 1; m_age = 1;
          m_prod = 8'(req0_a) * 8'(req0_b);
        end else if (e_r1) begin
          m_busy = 1; m_owner = 1; m_ptr = 0; m_age = 1;
          m_prod = 8'(req1_a) * 8'(req1_b);
        end
      end else if (m_age >= 2 && (m_owner ? rsp1_ready : rsp0_ready)) begin
        m_busy = 0;
      end else begin
        m_age++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       r, got;
    logic [3:0] a, b;
    int         n;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;

    // Reset holds everything low even with requests pending.
    tick();
    applyStimulus(1, 3, 5, 1, 2, 2, 1, 1);
    #1;
    checkOutput("rst_req0_ready", 9'(req0_ready), 9'd0);
    checkOutput("rst_req1_ready", 9'(req1_ready), 9'd0);
    checkOutput("rst_busy", 9'(busy), 9'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    #1;
    checkOutput("idle_busy", 9'(busy), 9'd0);

    // Single request from requester 0: 3*5.
    tick();
    applyStimulus(1, 3, 5, 0, 0, 0, 1, 1);
    #1;
    checkOutput("s31_req0_ready", 9'(req0_ready), 9'd1);
    checkOutput("s31_req1_ready", 9'(req1_ready), 9'd0);
    tick();
    applyStimulus(0, 3, 5, 0, 0, 0, 1, 1);
    #1;
    checkOutput("s31_mul_busy", 9'(busy), 9'd1);
    checkOutput("s31_mul_rsp0_valid", 9'(rsp0_valid), 9'd0);
    tick();
    #1;
    checkOutput("s31_rsp0_valid", 9'(rsp0_valid), 9'd1);
    checkOutput("s31_rsp0_p", 9'(rsp0_p), 9'd15);
    checkOutput("s31_rsp1_valid", 9'(rsp1_valid), 9'd0);
    tick();
    #1;
    checkOutput("s31_done_busy", 9'(busy), 9'd0);

    // Contention after reset: requester 0 first, then 1, then the pointer alternates.
    doReset();
    tick();
    applyStimulus(1, 15, 15, 1, 9, 0, 1, 1);
    #1;
    checkOutput("s32_first_req0_ready", 9'(req0_ready), 9'd1);
    checkOutput("s32_first_req1_ready", 9'(req1_ready), 9'd0);
    tick();
    applyStimulus(0, 15, 15, 1, 9, 0, 1, 1);
    tick();
    #1;
    checkOutput("s32_rsp0_p", 9'(rsp0_p), 9'd225);
    tick();
    #1;
    checkOutput("s32_second_req1_ready", 9'(req1_ready), 9'd1);
    checkOutput("s32_second_req0_ready", 9'(req0_ready), 9'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 9, 0, 1, 1);
    tick();
    #1;
    checkOutput("s32_rsp1_valid", 9'(rsp1_valid), 9'd1);
    checkOutput("s32_rsp1_p", 9'(rsp1_p), 9'd0);
    tick();
    applyStimulus(1, 2, 3, 1, 4, 5, 1, 1);
    #1;
    checkOutput("s32_third_req0_ready", 9'(req0_ready), 9'd1);
    tick();
    tick();
    #1;
    checkOutput("s32_third_rsp0_p", 9'(rsp0_p), 9'd6);
    tick();
    #1;
    checkOutput("s32_fourth_req1_ready", 9'(req1_ready), 9'd1);
    checkOutput("s32_fourth_req0_ready", 9'(req0_ready), 9'd0);
    drain();

    // Back-pressure on requester 1: 12*11 held through a 5-cycle stall.
    tick();
    applyStimulus(0, 0, 0, 1, 12, 11, 0, 0);
    #1;
    checkOutput("s33_req1_ready", 9'(req1_ready), 9'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 12, 11, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      applyStimulus(1, 1, 1, 0, 12, 11, 1, 0);
      #1;
      checkOutput("s33_hold_rsp1_valid", 9'(rsp1_valid), 9'd1);
      checkOutput("s33_hold_rsp1_p", 9'(rsp1_p), 9'd132);
      checkOutput("s33_hold_busy", 9'(busy), 9'd1);
      checkOutput("s33_hold_req0_ready", 9'(req0_ready), 9'd0);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 12, 11, 0, 1);
    #1;
    checkOutput("s33_release_rsp1_valid", 9'(rsp1_valid), 9'd1);
    tick();
    #1;
    checkOutput("s33_after_rsp1_valid", 9'(rsp1_valid), 9'd0);
    checkOutput("s33_after_rsp1_p", 9'(rsp1_p), 9'd0);
    checkOutput("s33_after_busy", 9'(busy), 9'd0);

    // Reset while multiplying discards the job; a request held across release is new.
    tick();
    applyStimulus(1, 7, 9, 0, 0, 0, 1, 1);
    #1;
    checkOutput("s34_req0_ready", 9'(req0_ready), 9'd1);
    tick();
    applyStimulus(0, 7, 9, 1, 6, 6, 1, 1);
    #1;
    checkOutput("s34_mul_busy", 9'(busy), 9'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("s34_rst_busy", 9'(busy), 9'd0);
    checkOutput("s34_rst_req1_ready", 9'(req1_ready), 9'd0);
    checkOutput("s34_rst_rsp0_valid", 9'(rsp0_valid), 9'd0);
    checkOutput("s34_rst_rsp0_p", 9'(rsp0_p), 9'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("s34_release_req1_ready", 9'(req1_ready), 9'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 6, 6, 1, 1);
    tick();
    #1;
    checkOutput("s34_no_stale_rsp0", 9'(rsp0_valid), 9'd0);
    checkOutput("s34_rsp1_p", 9'(rsp1_p), 9'd36);
    drain();

    // Every operand pair, alternating requesters, with random response stalls.
    for (int k = 0; k < 256; k++) begin
      r = k[0];
      a = 4'(k >> 4);
      b = 4'(k);
      tick();
      applyStimulus(!r, a, b, r, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      got = r ? req1_ready : req0_ready;
      n = 0;
      while (!got && n < 8) begin
        tick();
        #1;
        got = r ? req1_ready : req0_ready;
        n++;
      end
      if (!got) failTimeout("sweep_accept");
      n = 0;
      got = 0;
      while (!got && n < 40) begin
        tick();
        applyStimulus(0, a, b, 0, a, b, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
        #1;
        got = r ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready);
        n++;
      end
      if (!got) failTimeout("sweep_response");
    end
    drain();

    // Free-running random traffic.
    for (int i = 0; i < 1500; i++) begin
      tick();
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                    1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
